// File: rtl/boundary_scan_pkg.sv
// rtl/boundary_scan_pkg.sv - shared types and helpers for the boundary-scan ring
package boundary_scan_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SHIFT   = 2'd2,
    UPDATE  = 2'd3
  } bs_state_t;

  // Counter must reach len-1; +1 keeps it wide enough for any len
  function automatic int CNT_W(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/boundary_scan_cell.sv
// rtl/boundary_scan_cell.sv - one capture/shift/update boundary-scan bit
module boundary_scan_cell
  import boundary_scan_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic capture,
  input  logic shift,
  input  logic update,
  input  logic par_in,
  input  logic sin,
  output logic sout,
  output logic upd
);

  logic q;

  // Update latch is separate from the shift flop so pins stay put while shifting
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q   <= 1'b0;
      upd <= 1'b0;
    end else begin
      if (capture)
        q <= par_in;
      else if (shift)
        q <= sin;
      if (update)
        upd <= q;
    end
  end

  assign sout = q;

endmodule

// File: rtl/boundary_scan_chain.sv
// rtl/boundary_scan_chain.sv - boundary-scan ring with capture/shift/update sequencer
module boundary_scan_chain
  import boundary_scan_pkg::*;
#(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             testing,
  input  logic [N_IN-1:0]  pad_in,
  output logic [N_IN-1:0]  core_in,
  input  logic [N_OUT-1:0] core_out,
  output logic [N_OUT-1:0] pad_out,
  input  logic             sin,
  output logic             sout,
  input  logic             start,
  output logic             busy,
  output logic             done
);

  localparam int L  = N_IN + N_OUT;
  localparam int CW = CNT_W(L);

  bs_state_t       state;
  logic [CW-1:0]   cnt;
  logic [L:0]      link;
  logic [L-1:0]    par;
  logic [L-1:0]    upd;

  assign par     = {core_out, pad_in};
  assign link[L] = sin;

  // link[i] is cell i's shift output; cell i takes its serial input from cell i+1
  for (genvar i = 0; i < L; i++) begin : g_cell
    boundary_scan_cell u_cell (
      .clock   (clock),
      .reset   (reset),
      .capture (state == CAPTURE),
      .shift   (state == SHIFT),
      .update  (state == UPDATE),
      .par_in  (par[i]),
      .sin     (link[i+1]),
      .sout    (link[i]),
      .upd     (upd[i])
    );
  end

  assign sout    = link[0];
  assign core_in = testing ? upd[N_IN-1:0] : pad_in;
  assign pad_out = testing ? upd[L-1:N_IN] : core_out;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= CAPTURE;
            busy  <= 1'b1;
          end
        end
        CAPTURE: begin
          cnt   <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(L - 1)) begin
            state <= UPDATE;
            done  <= 1'b1;
          end
        end
        UPDATE: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/boundary_scan_chain.md
# boundary_scan_chain

Parametrised boundary-scan ring with capture/shift/update staging and a built-in sequencer. It wraps a core's `N_IN` input pins and `N_OUT` output pins. A single `start` pulse runs a full capture–shift–update pass through one serial chain. Update latches keep the pins stable while the chain shifts, which the single-flop cells lacked. It sits between the pad ring and the core, and the test controller drives `sin`, `start` and `testing`.

## Interface
- `N_IN`, 4: number of core input pins wrapped (≥1)
- `N_OUT`, 4: number of core output pins wrapped (≥1)
- `L` (localparam), `N_IN+N_OUT`: chain length
- `clock`  in  1  clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `testing`  in  1  1: pins driven from update latches; 0: functional pass-through
- `pad_in`  in  `N_IN`  values from input pads
- `core_in`  out  `N_IN`  values to core inputs
- `core_out`  in  `N_OUT`  values from core outputs
- `pad_out`  out  `N_OUT`  values to output pads
- `sin`  in  1  serial scan data in
- `sout`  out  1  serial scan data out
- `start`  in  1  request one scan pass; sampled only in IDLE
- `busy`  out  1  high whenever state ≠ IDLE
- `done`  out  1  high for exactly the UPDATE cycle

## Operation
- Storage:
  - chain register `chain[L-1:0]`
  - update latches `upd_in[N_IN-1:0]` and `upd_out[N_OUT-1:0]`
  - shift counter `cnt`, width `$clog2(L+1)`
- Mapping:
  - `chain[N_IN-1:0]` ↔ input pins
  - `chain[L-1:N_IN]` ↔ output pins
  - bit i of each field maps to pin i
- Shift direction: `sin` enters `chain[L-1]`, data moves toward index 0, and `sout = chain[0]` (combinational, always).
- Pin muxes (combinational):
  - `core_in = testing ? upd_in : pad_in`
  - `pad_out = testing ? upd_out : core_out`
- FSM states: IDLE, CAPTURE, SHIFT, UPDATE.
  - **IDLE**: chain holds. If `start`=1 → CAPTURE.
  - **CAPTURE** (1 cycle): at the edge, `chain <= {core_out, pad_in}` and `cnt <= 0`. → SHIFT.
  - **SHIFT** (exactly L cycles): each edge does `chain <= {sin, chain[L-1:1]}` and `cnt <= cnt+1`. When `cnt == L-1`, this is the final shift → UPDATE.
  - **UPDATE** (1 cycle): `done`=1. At the edge, `upd_in <= chain[N_IN-1:0]` and `upd_out <= chain[L-1:N_IN]`. → IDLE.
- Capture and update happen regardless of `testing`; `testing` affects only the pin muxes.
- Update latches change only at the UPDATE edge, so pins never ripple during SHIFT.
- `start` outside IDLE is ignored and not queued. `start` held high re-triggers a new pass from IDLE.
- `testing` toggling mid-pass does not disturb the FSM; the muxes switch immediately.

## Timing
- Reset state: all registers 0, state IDLE, `busy`=0, `done`=0, `sout`=0.
- Output values in reset:
  - `core_in` = `pad_in` when `testing`=0, else 0
  - `pad_out` = `core_out` when `testing`=0, else 0
- Sequence, with `start` sampled high at edge k:
  - cycle k+1: CAPTURE
  - cycles k+2..k+L+1: SHIFT
  - cycle k+L+2: UPDATE, `done`=1
  - edge k+L+3: back in IDLE
  - Total pass: L+2 cycles after the start edge; `busy`=1 from k+1 through k+L+2.
- Serial timing:
  - Tester presents `sin` before each SHIFT edge.
  - `sout` before the first SHIFT edge is captured `pad_in[0]`.
  - Before SHIFT edge j (j = 0..L-1), `sout` shows captured chain bit j.
  - The `sin` bit shifted at SHIFT edge j lands in `chain[j]` after the final shift, i.e. first-in ends at index 0.
- Reset mid-pass: immediate return to IDLE with all registers cleared. No partial update is applied.

## Structure
- Package `boundary_scan_pkg`:
  - state enum `bs_state_t` (IDLE, CAPTURE, SHIFT, UPDATE)
  - `CNT_W(L)` width helper function
- Sub-module `boundary_scan_cell`: one capture/shift/update bit with inputs `capture`, `shift`, `update`, `par_in`, `sin`, and outputs `sout`, `upd`.
  - Instantiate it L times via generate.
  - The top level holds the FSM, the counter and the pin muxes.

## Test plan
- **Reset:** assert `reset` mid-SHIFT of a pass with `testing`=1 → `busy`=0, `sout`=0, `core_in`=4'h0, `pad_out`=4'h0 the same cycle. The next `start` runs a normal full pass.
- **Capture readout:** N_IN=N_OUT=4, `pad_in`=4'hA, `core_out`=4'h5, `start` pulse, `sin`=0 → `sout` sequence over the 8 SHIFT cycles is 0,1,0,1,1,0,1,0.
- **Update/drive:** shift in 8'b1100_0011 (first bit = bit 0), `testing`=1 → after the UPDATE edge `core_in`=4'h3 and `pad_out`=4'hC. Both values are unchanged during all SHIFT cycles of a following pass until its UPDATE edge.
- **Pass-through:** `testing`=0, `pad_in`=4'h9, `core_out`=4'h6 during a full pass → `core_in`=4'h9 and `pad_out`=4'h6 every cycle.
- **Handshake:** pulse `start` at k → `busy` high cycles k+1..k+10, `done` high only at k+10. A `start` pulse at k+4 is ignored, giving no extra pass.
- **Back-to-back:** `start` held high → the second CAPTURE begins at k+12 and `done` pulses every 11 cycles.
